// File: rtl/counter_enable_seq.sv
// Burst-schedule enable generator for first_counter: wait D, enable for R, repeat N extra times.
// Optional abort input/aborted flag are built when COUNTER_ENABLE_SEQ_ABORT_EN is defined.
module counter_enable_seq #(
   parameter int DELAY_W = 4,
   parameter int RUN_W   = 8,
   parameter int REP_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [DELAY_W-1:0] i_delay_cycles,
   input  logic [RUN_W-1:0]   i_run_cycles,
   input  logic [REP_W-1:0]   i_repeat_cnt,
`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
   input  logic               i_abort,
   output logic               o_aborted,
`endif
   output logic               o_enable,
   output logic               o_busy,
   output logic               o_done,
   output logic [REP_W-1:0]   o_burst_idx,
   output logic [1:0]         o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [DELAY_W-1:0] r_d, r_dcnt, w_dcnt_nxt;
   logic [RUN_W-1:0]   r_r, r_rcnt, w_rcnt_nxt;
   logic [REP_W-1:0]   r_n, r_idx, w_idx_nxt;
   logic               r_enable, r_busy, r_done;
   logic               w_abort, w_run_end, w_last;

`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
   logic r_aborted, w_abort_hit;
   assign w_abort     = i_abort;
   // The natural end of the last burst takes priority over a coincident abort.
   assign w_abort_hit = w_abort && ((r_state == S_DELAY) || ((r_state == S_RUN) && !w_last));
   assign o_aborted   = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   assign w_run_end = (r_rcnt == '0);
   assign w_last    = w_run_end && (r_idx == r_n);

   always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_rcnt_nxt  = r_rcnt;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            w_idx_nxt = '0;
            if (i_start) begin
               if (i_run_cycles == '0) begin
                  w_state_nxt = S_DONE;
               end else if (i_delay_cycles == '0) begin
                  w_state_nxt = S_RUN;
                  w_rcnt_nxt  = i_run_cycles - RUN_W'(1);
               end else begin
                  w_state_nxt = S_DELAY;
                  w_dcnt_nxt  = i_delay_cycles - DELAY_W'(1);
               end
            end
         end
         S_DELAY: begin
            if (w_abort) begin
               w_state_nxt = S_DONE;
            end else if (r_dcnt == '0) begin
               w_state_nxt = S_RUN;
               w_rcnt_nxt  = r_r - RUN_W'(1);
            end else begin
               w_dcnt_nxt = r_dcnt - DELAY_W'(1);
            end
         end
         S_RUN: begin
            if (w_last || w_abort) begin
               w_state_nxt = S_DONE;
            end else if (w_run_end) begin
               w_idx_nxt = r_idx + REP_W'(1);
               if (r_d == '0) begin
                  w_rcnt_nxt = r_r - RUN_W'(1);
               end else begin
                  w_state_nxt = S_DELAY;
                  w_dcnt_nxt  = r_d - DELAY_W'(1);
               end
            end else begin
               w_rcnt_nxt = r_rcnt - RUN_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_d      <= '0;
         r_r      <= '0;
         r_n      <= '0;
         r_dcnt   <= '0;
         r_rcnt   <= '0;
         r_idx    <= '0;
         r_enable <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
         r_aborted <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_rcnt  <= w_rcnt_nxt;
         r_idx   <= w_idx_nxt;
         if ((r_state == S_IDLE) && i_start) begin
            r_d <= i_delay_cycles;
            r_r <= i_run_cycles;
            r_n <= i_repeat_cnt;
         end
         r_enable <= (w_state_nxt == S_RUN);
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done   <= (w_state_nxt == S_DONE);
`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
         r_aborted <= w_abort_hit;
`endif
      end
   end

   assign o_enable    = r_enable;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_burst_idx = r_idx;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_counter_enable_seq.sv
// Directed bench for counter_enable_seq: vector table of burst schedules plus corner sequences.
// Abort sequences are compiled in when COUNTER_ENABLE_SEQ_ABORT_EN is defined.
module tb_counter_enable_seq;
   localparam int DELAY_W = 4;
   localparam int RUN_W   = 8;
   localparam int REP_W   = 4;

   logic               clk;
   logic               rst_n;
   logic               i_start;
   logic [DELAY_W-1:0] i_delay_cycles;
   logic [RUN_W-1:0]   i_run_cycles;
   logic [REP_W-1:0]   i_repeat_cnt;
   logic               o_enable, o_busy, o_done;
   logic [REP_W-1:0]   o_burst_idx;
   logic [1:0]         o_dbg_state;
`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
   logic               i_abort;
   logic               o_aborted;
`endif

   counter_enable_seq #(.DELAY_W(DELAY_W), .RUN_W(RUN_W), .REP_W(REP_W)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (i_start),
      .i_delay_cycles (i_delay_cycles),
      .i_run_cycles   (i_run_cycles),
      .i_repeat_cnt   (i_repeat_cnt),
`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
      .i_abort        (i_abort),
      .o_aborted      (o_aborted),
`endif
      .o_enable       (o_enable),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_burst_idx    (o_burst_idx),
      .o_dbg_state    (o_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Sample index i means "just after edge E0+i"; mask bit i is enable at that sample.
   typedef struct {
      int          d;
      int          r;
      int          n;
      logic [31:0] en_mask;
      int          en_cnt;
      int          done_at;
      int          idx_done;
   } vec_t;

   vec_t vecs[10];

   task automatic run_vec(input int k);
      vec_t        v;
      logic [31:0] obs;
      int          en_cnt, done_i, busy_bad, idx_d;
      v = vecs[k]; obs = '0; en_cnt = 0; done_i = -1; busy_bad = 0; idx_d = -1;
      @(negedge clk);
      i_delay_cycles = DELAY_W'(v.d);
      i_run_cycles   = RUN_W'(v.r);
      i_repeat_cnt   = REP_W'(v.n);
      i_start        = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (i == 0) begin
            i_start        = 1'b0;
            i_delay_cycles = DELAY_W'($urandom_range(0, 15));
            i_run_cycles   = RUN_W'($urandom_range(0, 255));
            i_repeat_cnt   = REP_W'($urandom_range(0, 15));
         end
         if (o_enable) begin
            en_cnt++;
            if (i < 32) obs[i] = 1'b1;
         end
         if (!o_busy) busy_bad++;
         if (o_done) begin
            done_i = i;
            idx_d  = int'(o_burst_idx);
            break;
         end
      end
      check($sformatf("v%0d_en_mask", k), obs, v.en_mask);
      check($sformatf("v%0d_en_count", k), en_cnt, v.en_cnt);
      check($sformatf("v%0d_done_at", k), done_i, v.done_at);
      check($sformatf("v%0d_idx_at_done", k), idx_d, v.idx_done);
      check($sformatf("v%0d_busy_gaps", k), busy_bad, 0);
      @(negedge clk);
      check($sformatf("v%0d_post_busy", k), o_busy, 0);
      check($sformatf("v%0d_post_done", k), o_done, 0);
      check($sformatf("v%0d_post_idx", k), o_burst_idx, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] busy_m, en_m, done_m;
      int          en_cnt, done_cnt, wait_i;
      int          exp_idx[9];
      vecs[0] = '{2, 5, 0, 32'h0000_007C, 5, 7, 0};
      vecs[1] = '{0, 3, 2, 32'h0000_01FF, 9, 9, 2};
      vecs[2] = '{1, 1, 3, 32'h0000_00AA, 4, 8, 3};
      vecs[3] = '{3, 0, 5, 32'h0000_0000, 0, 0, 0};
      vecs[4] = '{0, 0, 0, 32'h0000_0000, 0, 0, 0};
      vecs[5] = '{0, 1, 0, 32'h0000_0001, 1, 1, 0};
      vecs[6] = '{2, 2, 1, 32'h0000_00CC, 4, 8, 1};
      vecs[7] = '{1, 3, 1, 32'h0000_00EE, 6, 8, 1};
      vecs[8] = '{0, 2, 3, 32'h0000_00FF, 8, 8, 3};
      vecs[9] = '{15, 255, 15, 32'hFFFF_8000, 4080, 4320, 15};
      exp_idx = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

      rst_n = 1'b0; i_start = 1'b0;
      i_delay_cycles = '0; i_run_cycles = '0; i_repeat_cnt = '0;
`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
      i_abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_enable", o_enable, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_idx", o_burst_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", o_busy, 0);

      for (int k = 0; k < 10; k++) run_vec(k);

      // Burst index steps every R cycles when D==0.
      @(negedge clk);
      i_delay_cycles = 4'd0; i_run_cycles = 8'd3; i_repeat_cnt = 4'd2; i_start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         i_start = 1'b0;
         check($sformatf("idx_seq_%0d", i), o_burst_idx, exp_idx[i]);
         check($sformatf("idx_seq_en_%0d", i), o_enable, 1);
      end
      @(negedge clk);
      check("idx_seq_done", o_done, 1);
      @(negedge clk);

      // start held high: second schedule is accepted only after one IDLE cycle.
      @(negedge clk);
      i_delay_cycles = 4'd2; i_run_cycles = 8'd2; i_repeat_cnt = 4'd1; i_start = 1'b1;
      @(posedge clk);
      busy_m = '0; en_m = '0; done_m = '0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         busy_m[i] = o_busy; en_m[i] = o_enable; done_m[i] = o_done;
      end
      i_start = 1'b0;
      check("held_busy_mask", busy_m, 16'h3DFF);
      check("held_en_mask", en_m, 16'h30CC);
      check("held_done_mask", done_m, 16'h0100);
      wait_i = 0;
      while (o_busy && wait_i < 50) begin
         @(negedge clk);
         wait_i++;
      end
      check("held_second_finishes", o_busy, 0);

      // Asynchronous reset in the middle of a burst.
      @(negedge clk);
      i_delay_cycles = 4'd0; i_run_cycles = 8'd10; i_repeat_cnt = 4'd0; i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      check("midrun_enable", o_enable, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_enable", o_enable, 0);
      check("async_rst_busy", o_busy, 0);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (o_done) done_cnt++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (o_done) done_cnt++;
      end
      check("async_rst_no_done", done_cnt, 0);
      check("async_rst_idle_busy", o_busy, 0);

`ifdef COUNTER_ENABLE_SEQ_ABORT_EN
      // Abort at the 4th RUN cycle: three enables, then done with aborted.
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         i_delay_cycles = 4'd0; i_run_cycles = (t == 0) ? 8'd10 : 8'd3;
         i_repeat_cnt = 4'd0; i_start = 1'b1;
         @(posedge clk);
         en_cnt = 0; done_m = '0; busy_m = '0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) i_start = 1'b0;
            if (o_enable) en_cnt++;
            done_m[i] = o_done;
            busy_m[i] = o_aborted;
            if (i == 2) i_abort = 1'b1;
            if (i == 3) i_abort = 1'b0;
         end
         check($sformatf("abort%0d_en_count", t), en_cnt, 3);
         check($sformatf("abort%0d_done_mask", t), done_m, 16'h0008);
         check($sformatf("abort%0d_aborted_mask", t), busy_m, (t == 0) ? 16'h0008 : 16'h0000);
         check($sformatf("abort%0d_post_busy", t), o_busy, 0);
      end
      @(negedge clk);
      i_abort = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_idle_busy", o_busy, 0);
      check("abort_idle_aborted", o_aborted, 0);
      i_abort = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
